// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipelined control unit: opcodes,
// ALU-op codes and the packed EX/M/WB control bundle.
package pipe_ctrl_pkg;

    // Opcodes understood by the decoder
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Width of the ALU-op field carried inside the bundle
    localparam int CTRL_ALU_OP_W = 3;

    // ALU operation codes
    localparam logic [CTRL_ALU_OP_W-1:0] ALU_RTYPE = 3'b100;
    localparam logic [CTRL_ALU_OP_W-1:0] ALU_SUB   = 3'b001;
    localparam logic [CTRL_ALU_OP_W-1:0] ALU_SLT   = 3'b010;
    localparam logic [CTRL_ALU_OP_W-1:0] ALU_ADD   = 3'b000;

    // Controls consumed in EX
    typedef struct packed {
        logic [CTRL_ALU_OP_W-1:0] alu_op;
        logic                     alu_src;
        logic                     reg_dst;
        logic                     illegal;
    } ex_ctrl_t;

    // Controls consumed in MEM
    typedef struct packed {
        logic branch;
        logic branch_ne;
        logic mem_read;
        logic mem_write;
    } m_ctrl_t;

    // Controls consumed in WB
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    // Full bundle as produced by the decoder and held in ID/EX
    typedef struct packed {
        ex_ctrl_t ex;
        m_ctrl_t  m;
        wb_ctrl_t wb;
    } ctrl_bundle_t;

    // What the stage registers do on the next rising edge
    typedef enum logic [1:0] {
        ADV_NORMAL = 2'b00,
        ADV_BUBBLE = 2'b01,
        ADV_FLUSH  = 2'b10
    } adv_e;

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// Bus between the datapath and pipe_ctrl_unit. The datapath side is the
// master (drives the ID-stage instruction fields and flush), the control
// unit is the slave. With CTRL_PERF_CNT_EN defined the stall/flush
// performance counters are carried here as well.
interface pipe_ctrl_unit_if #(
    parameter int ALU_OP_W   = 3,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic [5:0]            instr_op_i;
    logic                  id_valid_i;
    logic [REG_ADDR_W-1:0] id_rs_i;
    logic [REG_ADDR_W-1:0] id_rt_i;
    logic                  flush_i;
    logic                  stall_o;
    logic [ALU_OP_W-1:0]   ex_alu_op_o;
    logic                  ex_alu_src_o;
    logic                  ex_reg_dst_o;
    logic                  ex_illegal_o;
    logic                  mem_branch_o;
    logic                  mem_branch_ne_o;
    logic                  mem_read_o;
    logic                  mem_write_o;
    logic                  wb_reg_write_o;
    logic                  wb_mem_to_reg_o;
`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0]      stall_cnt_o;
    logic [CNT_W-1:0]      flush_cnt_o;

    modport slave (
        input  instr_op_i, id_valid_i, id_rs_i, id_rt_i, flush_i,
        output stall_o, ex_alu_op_o, ex_alu_src_o, ex_reg_dst_o, ex_illegal_o,
               mem_branch_o, mem_branch_ne_o, mem_read_o, mem_write_o,
               wb_reg_write_o, wb_mem_to_reg_o, stall_cnt_o, flush_cnt_o
    );

    modport master (
        output instr_op_i, id_valid_i, id_rs_i, id_rt_i, flush_i,
        input  stall_o, ex_alu_op_o, ex_alu_src_o, ex_reg_dst_o, ex_illegal_o,
               mem_branch_o, mem_branch_ne_o, mem_read_o, mem_write_o,
               wb_reg_write_o, wb_mem_to_reg_o, stall_cnt_o, flush_cnt_o
    );
`else
    modport slave (
        input  instr_op_i, id_valid_i, id_rs_i, id_rt_i, flush_i,
        output stall_o, ex_alu_op_o, ex_alu_src_o, ex_reg_dst_o, ex_illegal_o,
               mem_branch_o, mem_branch_ne_o, mem_read_o, mem_write_o,
               wb_reg_write_o, wb_mem_to_reg_o
    );

    modport master (
        output instr_op_i, id_valid_i, id_rs_i, id_rt_i, flush_i,
        input  stall_o, ex_alu_op_o, ex_alu_src_o, ex_reg_dst_o, ex_illegal_o,
               mem_branch_o, mem_branch_ne_o, mem_read_o, mem_write_o,
               wb_reg_write_o, wb_mem_to_reg_o
    );
`endif

endinterface

// File: rtl/pipe_ctrl_unit_ctrl_decode.sv
// Purely combinational main decoder: opcode -> control bundle, plus the
// uses_rt flag for hazard detection and the illegal-opcode flag. Every
// unknown opcode yields an all-zero bundle with illegal set, never X.
module ctrl_decode
    import pipe_ctrl_pkg::*;
(
    input  logic [5:0]   op_i,
    output ctrl_bundle_t ctrl_o,
    output logic         uses_rt_o,
    output logic         illegal_o
);

    // Opcode table; fields not set in a branch stay at their zero default
    always_comb begin
        ctrl_o    = '0;
        uses_rt_o = 1'b0;
        illegal_o = 1'b0;
        case (op_i)
            OP_RTYPE: begin
                ctrl_o.ex.reg_dst   = 1'b1;
                ctrl_o.wb.reg_write = 1'b1;
                ctrl_o.ex.alu_op    = ALU_RTYPE;
                uses_rt_o           = 1'b1;
            end
            OP_BEQ: begin
                ctrl_o.m.branch  = 1'b1;
                ctrl_o.ex.alu_op = ALU_SUB;
                uses_rt_o        = 1'b1;
            end
            OP_BNE: begin
                ctrl_o.m.branch    = 1'b1;
                ctrl_o.m.branch_ne = 1'b1;
                ctrl_o.ex.alu_op   = ALU_SUB;
                uses_rt_o          = 1'b1;
            end
            OP_ADDI: begin
                ctrl_o.ex.alu_src   = 1'b1;
                ctrl_o.wb.reg_write = 1'b1;
                ctrl_o.ex.alu_op    = ALU_ADD;
            end
            OP_SLTI: begin
                ctrl_o.ex.alu_src   = 1'b1;
                ctrl_o.wb.reg_write = 1'b1;
                ctrl_o.ex.alu_op    = ALU_SLT;
            end
            OP_LW: begin
                ctrl_o.ex.alu_src    = 1'b1;
                ctrl_o.m.mem_read    = 1'b1;
                ctrl_o.wb.mem_to_reg = 1'b1;
                ctrl_o.wb.reg_write  = 1'b1;
                ctrl_o.ex.alu_op     = ALU_ADD;
            end
            OP_SW: begin
                ctrl_o.ex.alu_src  = 1'b1;
                ctrl_o.m.mem_write = 1'b1;
                ctrl_o.ex.alu_op   = ALU_ADD;
                uses_rt_o          = 1'b1;
            end
            default: begin
                ctrl_o.ex.illegal = 1'b1;
                illegal_o         = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit for the 5-stage MIPS pipeline. Decodes the ID
// opcode and carries the control bundle through ID/EX, EX/MEM and MEM/WB.
// Detects load-use hazards (1-cycle stall plus bubble) and handles branch
// flushes resolved in MEM; a flush wins over a stall.
// Optional feature macro: CTRL_PERF_CNT_EN (saturating stall/flush counters).
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int ALU_OP_W   = 3,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    pipe_ctrl_unit_if.slave  bus
);

    ctrl_bundle_t          dec_ctrl;
    logic                  dec_uses_rt;
    logic                  dec_illegal;

    ctrl_bundle_t          idex_q,     idex_d;
    logic [REG_ADDR_W-1:0] idex_rt_q,  idex_rt_d;
    m_ctrl_t               exmem_m_q,  exmem_m_d;
    wb_ctrl_t              exmem_wb_q, exmem_wb_d;
    wb_ctrl_t              memwb_q,    memwb_d;

    logic                  stall;
    logic                  rt_nonzero;
    logic                  rs_hit;
    logic                  rt_hit;
    adv_e                  adv;

    ctrl_decode u_decode (
        .op_i      (bus.instr_op_i),
        .ctrl_o    (dec_ctrl),
        .uses_rt_o (dec_uses_rt),
        .illegal_o (dec_illegal)
    );

    // Load-use hazard: the load in EX writes a register the ID instruction reads
    always_comb begin
        rt_nonzero = (idex_rt_q != {REG_ADDR_W{1'b0}});
        rs_hit     = (idex_rt_q == bus.id_rs_i);
        rt_hit     = dec_uses_rt & (idex_rt_q == bus.id_rt_i);
        stall      = idex_q.m.mem_read & bus.id_valid_i & rt_nonzero & (rs_hit | rt_hit);
    end

    // Choose the advance mode for this edge; flush beats stall beats empty ID
    always_comb begin
        adv = ADV_NORMAL;
        if (bus.flush_i) begin
            adv = ADV_FLUSH;
        end else if (stall || !bus.id_valid_i) begin
            adv = ADV_BUBBLE;
        end else begin
            adv = ADV_NORMAL;
        end
    end

    // Next-state of the stage registers; later stages advance unless flushed
    always_comb begin
        idex_d     = '0;
        idex_rt_d  = {REG_ADDR_W{1'b0}};
        exmem_m_d  = idex_q.m;
        exmem_wb_d = idex_q.wb;
        memwb_d    = exmem_wb_q;
        case (adv)
            ADV_FLUSH: begin
                exmem_m_d  = '0;
                exmem_wb_d = '0;
            end
            ADV_BUBBLE: begin
                idex_d    = '0;
                idex_rt_d = {REG_ADDR_W{1'b0}};
            end
            ADV_NORMAL: begin
                idex_d            = dec_ctrl;
                idex_d.ex.illegal = dec_illegal;
                idex_rt_d         = bus.id_rt_i;
            end
            default: begin
                idex_d    = '0;
                idex_rt_d = {REG_ADDR_W{1'b0}};
            end
        endcase
    end

    // Stage registers; reset discards all in-flight control
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            idex_q     <= '0;
            idex_rt_q  <= {REG_ADDR_W{1'b0}};
            exmem_m_q  <= '0;
            exmem_wb_q <= '0;
            memwb_q    <= '0;
        end else begin
            idex_q     <= idex_d;
            idex_rt_q  <= idex_rt_d;
            exmem_m_q  <= exmem_m_d;
            exmem_wb_q <= exmem_wb_d;
            memwb_q    <= memwb_d;
        end
    end

    assign bus.stall_o         = stall;
    assign bus.ex_alu_op_o     = ALU_OP_W'(idex_q.ex.alu_op);
    assign bus.ex_alu_src_o    = idex_q.ex.alu_src;
    assign bus.ex_reg_dst_o    = idex_q.ex.reg_dst;
    assign bus.ex_illegal_o    = idex_q.ex.illegal;
    assign bus.mem_branch_o    = exmem_m_q.branch;
    assign bus.mem_branch_ne_o = exmem_m_q.branch_ne;
    assign bus.mem_read_o      = exmem_m_q.mem_read;
    assign bus.mem_write_o     = exmem_m_q.mem_write;
    assign bus.wb_reg_write_o  = memwb_q.reg_write;
    assign bus.wb_mem_to_reg_o = memwb_q.mem_to_reg;

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Count stall cycles that were not overridden by a flush, and flush cycles
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && !bus.flush_i) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (bus.flush_i) begin
            flush_cnt_d = sat_inc(flush_cnt_q);
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Counter registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.stall_cnt_o = stall_cnt_q;
    assign bus.flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit. A reference model predicts the
// stall flag and the EX/MEM/WB outputs; predictions are queued when the
// stimulus is driven and compared after the following clock edge.
module tb_pipe_ctrl_unit;

`ifdef CTRL_PERF_CNT_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 16;
`endif

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk_i = ~clk_i;

    pipe_ctrl_unit_if #(.ALU_OP_W(3), .REG_ADDR_W(5), .CNT_W(CNT_W)) bus ();

    pipe_ctrl_unit #(.ALU_OP_W(3), .REG_ADDR_W(5), .CNT_W(CNT_W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // model state: ex = {alu_op[3],src,dst,ill,br,bne,rd,wr,rw,m2r}
    logic [11:0] m_ex  = 12'd0;
    logic [4:0]  m_rt  = 5'd0;
    logic [5:0]  m_mem = 6'd0;
    logic [1:0]  m_wb  = 2'd0;
    int          m_scnt = 0;
    int          m_fcnt = 0;
    logic [11:0] exp_q[$];

    function automatic logic [11:0] ref_dec(input logic [5:0] op);
        case (op)
            6'b000000: return 12'b100_0_1_0_0_0_0_0_1_0;
            6'b000100: return 12'b001_0_0_0_1_0_0_0_0_0;
            6'b000101: return 12'b001_0_0_0_1_1_0_0_0_0;
            6'b001000: return 12'b000_1_0_0_0_0_0_0_1_0;
            6'b001010: return 12'b010_1_0_0_0_0_0_0_1_0;
            6'b100011: return 12'b000_1_0_0_0_0_1_0_1_1;
            6'b101011: return 12'b000_1_0_0_0_0_0_1_0_0;
            default:   return 12'b000_0_0_1_0_0_0_0_0_0;
        endcase
    endfunction

    function automatic logic ref_uses_rt(input logic [5:0] op);
        return (op == 6'b000000) || (op == 6'b000100) || (op == 6'b000101) || (op == 6'b101011);
    endfunction

    function automatic logic [11:0] dut_vec();
        return {bus.ex_alu_op_o, bus.ex_alu_src_o, bus.ex_reg_dst_o, bus.ex_illegal_o,
                bus.mem_branch_o, bus.mem_branch_ne_o, bus.mem_read_o, bus.mem_write_o,
                bus.wb_reg_write_o, bus.wb_mem_to_reg_o};
    endfunction

    task automatic drive_idle();
        bus.instr_op_i = 6'd0;
        bus.id_valid_i = 1'b0;
        bus.id_rs_i    = 5'd0;
        bus.id_rt_i    = 5'd0;
        bus.flush_i    = 1'b0;
    endtask

    task automatic clear_model();
        m_ex = 12'd0; m_rt = 5'd0; m_mem = 6'd0; m_wb = 2'd0;
        m_scnt = 0; m_fcnt = 0;
        exp_q.delete();
    endtask

    // One pipeline cycle: retire the previous prediction, drive new inputs,
    // check the combinational stall and queue the post-edge prediction.
    task automatic step(input logic [5:0] op, input logic v, input logic [4:0] rs,
                        input logic [4:0] rt, input logic fl);
        logic [11:0] e;
        logic [11:0] g;
        logic        es;
        int          cmax;
        @(posedge clk_i);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = dut_vec();
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL sb_outs got=%b want=%b t=%0t", g, e, $time);
            end
        end
        bus.instr_op_i = op;
        bus.id_valid_i = v;
        bus.id_rs_i    = rs;
        bus.id_rt_i    = rt;
        bus.flush_i    = fl;
        #1;
        es = m_ex[3] & v & (m_rt != 5'd0) & ((m_rt == rs) | (ref_uses_rt(op) & (m_rt == rt)));
        total++;
        if (bus.stall_o !== es) begin
            bad++;
            $display("FAIL sb_stall got=%b want=%b t=%0t", bus.stall_o, es, $time);
        end
        cmax = (1 << CNT_W) - 1;
        if (es && !fl && m_scnt < cmax) m_scnt++;
        if (fl && m_fcnt < cmax) m_fcnt++;
        m_wb  = m_mem[1:0];
        m_mem = fl ? 6'd0 : m_ex[5:0];
        if (fl || es || !v) begin
            m_ex = 12'd0;
            m_rt = 5'd0;
        end else begin
            m_ex = ref_dec(op);
            m_rt = rt;
        end
        exp_q.push_back({m_ex[11:6], m_mem[5:2], m_wb});
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        bus.instr_op_i = 6'b100011;
        bus.id_valid_i = 1'b1;
        bus.id_rs_i    = 5'd1;
        bus.id_rt_i    = 5'd8;
        bus.flush_i    = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        total++;
        if (dut_vec() !== 12'd0) begin
            bad++;
            $display("FAIL reset_outs got=%b want=0", dut_vec());
        end
        total++;
        if (bus.stall_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_stall got=%b want=0", bus.stall_o);
        end
        drive_idle();
        clear_model();
        #1;
        rst_i = 1'b1;
    endtask

    task automatic test_addi();
        step(6'b001000, 1'b1, 5'd1, 5'd2, 1'b0);
        step(6'd0, 1'b0, 5'd0, 5'd0, 1'b0);
        total++;
        if (bus.ex_alu_src_o !== 1'b1 || bus.ex_alu_op_o !== 3'b000) begin
            bad++;
            $display("FAIL addi_ex got src=%b op=%b want src=1 op=000", bus.ex_alu_src_o, bus.ex_alu_op_o);
        end
        step(6'd0, 1'b0, 5'd0, 5'd0, 1'b0);
        step(6'd0, 1'b0, 5'd0, 5'd0, 1'b0);
        total++;
        if (bus.wb_reg_write_o !== 1'b1) begin
            bad++;
            $display("FAIL addi_wb got=%b want=1", bus.wb_reg_write_o);
        end
    endtask

    task automatic test_load_use();
        step(6'b100011, 1'b1, 5'd1, 5'd8, 1'b0);
        step(6'b000000, 1'b1, 5'd8, 5'd9, 1'b0);
        total++;
        if (bus.stall_o !== 1'b1) begin
            bad++;
            $display("FAIL lu_stall got=%b want=1", bus.stall_o);
        end
        step(6'b000000, 1'b1, 5'd8, 5'd9, 1'b0);
        total++;
        if (bus.stall_o !== 1'b0) begin
            bad++;
            $display("FAIL lu_stall_drop got=%b want=0", bus.stall_o);
        end
        total++;
        if ({bus.ex_alu_op_o, bus.ex_alu_src_o, bus.ex_reg_dst_o, bus.ex_illegal_o} !== 6'd0
            || bus.mem_read_o !== 1'b1) begin
            bad++;
            $display("FAIL lu_bubble got ex=%b%b%b%b mem_read=%b want ex=0 mem_read=1",
                     bus.ex_alu_op_o, bus.ex_alu_src_o, bus.ex_reg_dst_o, bus.ex_illegal_o, bus.mem_read_o);
        end
        step(6'd0, 1'b0, 5'd0, 5'd0, 1'b0);
        total++;
        if (bus.ex_reg_dst_o !== 1'b1 || bus.ex_alu_op_o !== 3'b100) begin
            bad++;
            $display("FAIL lu_add_ex got dst=%b op=%b want dst=1 op=100", bus.ex_reg_dst_o, bus.ex_alu_op_o);
        end
    endtask

    task automatic test_zero_rt();
        step(6'b100011, 1'b1, 5'd1, 5'd0, 1'b0);
        step(6'b000000, 1'b1, 5'd0, 5'd0, 1'b0);
        total++;
        if (bus.stall_o !== 1'b0) begin
            bad++;
            $display("FAIL zero_rt_stall got=%b want=0", bus.stall_o);
        end
        step(6'd0, 1'b0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic test_flush_stall();
        step(6'b000100, 1'b1, 5'd1, 5'd2, 1'b0);
        step(6'b100011, 1'b1, 5'd3, 5'd8, 1'b0);
        step(6'b000000, 1'b1, 5'd8, 5'd8, 1'b1);
        total++;
        if (bus.stall_o !== 1'b1) begin
            bad++;
            $display("FAIL fl_stall got=%b want=1", bus.stall_o);
        end
        step(6'd0, 1'b0, 5'd0, 5'd0, 1'b0);
        total++;
        if (dut_vec() !== 12'd0 || bus.stall_o !== 1'b0) begin
            bad++;
            $display("FAIL fl_cleared got=%b stall=%b want=0", dut_vec(), bus.stall_o);
        end
    endtask

    task automatic test_bne_illegal();
        step(6'b000101, 1'b1, 5'd1, 5'd2, 1'b0);
        step(6'b111111, 1'b1, 5'd3, 5'd4, 1'b0);
        step(6'd0, 1'b0, 5'd0, 5'd0, 1'b0);
        total++;
        if (bus.mem_branch_o !== 1'b1 || bus.mem_branch_ne_o !== 1'b1) begin
            bad++;
            $display("FAIL bne_mem got br=%b bne=%b want 1 1", bus.mem_branch_o, bus.mem_branch_ne_o);
        end
        total++;
        if ({bus.ex_alu_op_o, bus.ex_alu_src_o, bus.ex_reg_dst_o, bus.ex_illegal_o} !== 6'b000001) begin
            bad++;
            $display("FAIL illegal_ex got=%b%b%b%b want=000001",
                     bus.ex_alu_op_o, bus.ex_alu_src_o, bus.ex_reg_dst_o, bus.ex_illegal_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [8];
        logic [5:0] op;
        ops = '{6'b000000, 6'b000100, 6'b000101, 6'b001000,
                6'b001010, 6'b100011, 6'b101011, 6'b110011};
        for (int i = 0; i < 80; i++) begin
            op = ops[$urandom_range(0, 7)];
            step(op, ($urandom_range(0, 7) != 0), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));
        end
    endtask

    task automatic test_midreset();
        step(6'b100011, 1'b1, 5'd1, 5'd5, 1'b0);
        step(6'b101011, 1'b1, 5'd2, 5'd3, 1'b0);
        step(6'b000000, 1'b1, 5'd4, 5'd6, 1'b0);
        #1;
        rst_i = 1'b0;
        #1;
        total++;
        if (dut_vec() !== 12'd0 || bus.stall_o !== 1'b0) begin
            bad++;
            $display("FAIL midreset got=%b stall=%b want=0", dut_vec(), bus.stall_o);
        end
        drive_idle();
        clear_model();
        @(posedge clk_i);
        #2;
        rst_i = 1'b1;
    endtask

`ifdef CTRL_PERF_CNT_EN
    task automatic test_perf();
        repeat (5) begin
            step(6'b100011, 1'b1, 5'd1, 5'd8, 1'b0);
            step(6'b000000, 1'b1, 5'd8, 5'd9, 1'b0);
            step(6'b000000, 1'b1, 5'd8, 5'd9, 1'b0);
        end
        total++;
        if (bus.stall_cnt_o !== 2'd3 || m_scnt != 3) begin
            bad++;
            $display("FAIL perf_stall got=%0d want=3 model=%0d", bus.stall_cnt_o, m_scnt);
        end
        step(6'd0, 1'b0, 5'd0, 5'd0, 1'b1);
        step(6'd0, 1'b0, 5'd0, 5'd0, 1'b1);
        step(6'd0, 1'b0, 5'd0, 5'd0, 1'b0);
        total++;
        if (bus.flush_cnt_o !== 2'd2) begin
            bad++;
            $display("FAIL perf_flush got=%0d want=2", bus.flush_cnt_o);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_idle();
        test_reset();
        test_addi();
        test_load_use();
        test_zero_rt();
        test_flush_stall();
        test_bne_illegal();
        test_back_to_back();
        test_midreset();
`ifdef CTRL_PERF_CNT_EN
        test_perf();
`endif
        step(6'd0, 1'b0, 5'd0, 5'd0, 1'b0);
        step(6'd0, 1'b0, 5'd0, 5'd0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
